// File: rtl/irq_ctrl_if.sv
// Interrupt controller bus: source lines, enable mask, and the core-side
// request/acknowledge/return handshake.
interface irq_ctrl_if #(
  parameter int N_IRQ = 16
);
  logic [N_IRQ-1:0] irq_lines;
  logic [N_IRQ-1:0] irq_en;
  logic             irq_ack;
  logic             irq_ret;
  logic             irq_req;
  logic [4:0]       irq_id;
  logic             irq_busy;
  logic [N_IRQ-1:0] irq_pending;

  // controller side
  modport master (
    input  irq_lines, irq_en, irq_ack, irq_ret,
    output irq_req, irq_id, irq_busy, irq_pending
  );

  // core / peripheral side
  modport slave (
    output irq_lines, irq_en, irq_ack, irq_ret,
    input  irq_req, irq_id, irq_busy, irq_pending
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: per-line pending capture, fixed
// priority select (lowest line wins) and a single in-flight req/ack/ret FSM.

module irq_line (
  input  logic clk,
  input  logic res,
  input  logic line,
  input  logic clr,
  output logic pend
);
  logic hist;

  // a new edge beats a simultaneous acknowledge-clear
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hist <= 1'b0;
      pend <= 1'b0;
    end else begin
      hist <= line;
      pend <= (pend & ~clr) | (line & ~hist);
    end
  end
endmodule

module irq_ctrl #(
  parameter int N_IRQ = 16
) (
  input  logic       clk,
  input  logic       res,
  irq_ctrl_if.master bus
);
  if (N_IRQ < 1 || N_IRQ > 31) begin : g_bad_n_irq
    $error("irq_ctrl: N_IRQ must be in 1..31 to fit a 5-bit ID");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_nx;
  logic [N_IRQ-1:0] pending, clr, cand;
  logic [4:0]       win_id, id_q, id_nx;
  logic             req_q, req_nx, busy_q, busy_nx;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    // only the line currently being acknowledged is cleared
    assign clr[i] = (state == REQ) && bus.irq_ack && (id_q == 5'(i + 1));
    irq_line u_line (
      .clk  (clk),
      .res  (res),
      .line (bus.irq_lines[i]),
      .clr  (clr[i]),
      .pend (pending[i])
    );
  end

  assign cand = pending & bus.irq_en;

  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i]) win_id = 5'(i + 1);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      id_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      req_q  <= req_nx;
      id_q   <= id_nx;
      busy_q <= busy_nx;
    end
  end

  // ack takes precedence over ret while a request is posted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_id != '0)  state_nx = REQ;
      REQ:     if (bus.irq_ack)   state_nx = SERVICE;
      SERVICE: if (bus.irq_ret)   state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_nx  = req_q;
    id_nx   = id_q;
    busy_nx = busy_q;
    case (state)
      IDLE: begin
        req_nx  = win_id != '0;
        id_nx   = win_id;
        busy_nx = 1'b0;
      end
      REQ: if (bus.irq_ack) begin
        req_nx  = 1'b0;
        busy_nx = 1'b1;
      end
      SERVICE: if (bus.irq_ret) begin
        id_nx   = '0;
        busy_nx = 1'b0;
      end
      default: begin
        req_nx  = 1'b0;
        id_nx   = '0;
        busy_nx = 1'b0;
      end
    endcase
  end

  assign bus.irq_req     = req_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_busy    = busy_q;
  assign bus.irq_pending = pending;
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: expected IDs queued as stimulus is driven, popped when
// a new request appears; state/pending checked inline.
module tb_irq_ctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [4:0] exp_q[$];
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.N_IRQ(N)) bus ();

  irq_ctrl #(.N_IRQ(N)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [4:0] id, input logic busy);
    chk({tag, "_req"},  bus.irq_req,  req);
    chk({tag, "_id"},   bus.irq_id,   id);
    chk({tag, "_busy"}, bus.irq_busy, busy);
  endtask

  // scoreboard: each rising irq_req must carry the next queued ID
  always @(negedge clk) begin
    if (bus.irq_req && !prev_req) begin
      if (exp_q.size() == 0) chk("sb_unexpected_req", bus.irq_id, 0);
      else                   chk("sb_id", bus.irq_id, exp_q.pop_front());
    end
    prev_req = bus.irq_req;
  end

  initial begin
    bus.irq_lines = '0;
    bus.irq_en    = '1;
    bus.irq_ack   = 1'b0;
    bus.irq_ret   = 1'b0;
    #2;
    chk_out("reset", 1'b0, 5'd0, 1'b0);
    chk("reset_pend", bus.irq_pending, 0);
    step(); step();
    res = 1'b0;
    step();

    // line 3: pending after 1 edge, request after 2, held until ack
    bus.irq_lines[3] = 1'b1; exp_q.push_back(5'd4);
    step();
    chk("t1_pend", bus.irq_pending, 16'h0008);
    chk("t1_req_early", bus.irq_req, 1'b0);
    step();
    chk_out("t1_req", 1'b1, 5'd4, 1'b0);
    step(); step();
    chk_out("t1_hold", 1'b1, 5'd4, 1'b0);

    // higher priority arrival does not preempt posted request
    bus.irq_lines[0] = 1'b1; exp_q.push_back(5'd1);
    step();
    chk("t2_nopreempt_id", bus.irq_id, 5'd4);
    chk("t2_pend", bus.irq_pending, 16'h0009);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    chk_out("t2_svc", 1'b0, 5'd4, 1'b1);
    chk("t2_pend_clr", bus.irq_pending, 16'h0001);
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    chk_out("t2_idle_gap", 1'b0, 5'd0, 1'b0);
    step();
    chk_out("t2_next", 1'b1, 5'd1, 1'b0);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    bus.irq_lines = '0;
    step();
    chk("t2_pend_empty", bus.irq_pending, 0);

    // masked line latches pending but is not requested until enabled
    bus.irq_en = ~(16'h0020);
    bus.irq_lines[5] = 1'b1;
    step();
    chk("t3_pend", bus.irq_pending, 16'h0020);
    step(); step();
    chk("t3_masked_req", bus.irq_req, 1'b0);
    bus.irq_en = '1; exp_q.push_back(5'd6);
    step();
    chk_out("t3_req", 1'b1, 5'd6, 1'b0);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    bus.irq_lines = '0;
    step();

    // new edge coinciding with ack-clear keeps the bit set
    bus.irq_lines[2] = 1'b1; exp_q.push_back(5'd3);
    step(); step();
    chk_out("t4_req", 1'b1, 5'd3, 1'b0);
    bus.irq_lines[2] = 1'b0;
    step();
    bus.irq_lines[2] = 1'b1; bus.irq_ack = 1'b1; exp_q.push_back(5'd3);
    step(); bus.irq_ack = 1'b0;
    chk("t4_busy", bus.irq_busy, 1'b1);
    chk("t4_set_wins", bus.irq_pending, 16'h0004);
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    chk_out("t4_idle", 1'b0, 5'd0, 1'b0);
    step();
    chk_out("t4_rereq", 1'b1, 5'd3, 1'b0);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    chk("t4_pend_clr", bus.irq_pending, 0);
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    bus.irq_lines = '0;
    step();

    // level held across ack/ret gives one request; stray ret/ack ignored
    bus.irq_lines[7] = 1'b1; exp_q.push_back(5'd8);
    step(); step();
    chk_out("t5_req", 1'b1, 5'd8, 1'b0);
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    chk_out("t5_stray_ret", 1'b1, 5'd8, 1'b0);
    bus.irq_ack = 1'b1; bus.irq_ret = 1'b1; step();
    bus.irq_ack = 1'b0; bus.irq_ret = 1'b0;
    chk_out("t5_ack_ret", 1'b0, 5'd8, 1'b1);
    bus.irq_ret = 1'b1; step(); bus.irq_ret = 1'b0;
    step(); step(); step();
    chk_out("t5_no_rereq", 1'b0, 5'd0, 1'b0);
    chk("t5_pend", bus.irq_pending, 0);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    step();
    chk_out("t5_stray_ack", 1'b0, 5'd0, 1'b0);
    bus.irq_lines = '0;
    step();

    // reach SERVICE with pending=0x0011, then async reset mid-cycle
    bus.irq_lines[0] = 1'b1; exp_q.push_back(5'd1);
    step(); step();
    chk_out("t6_req", 1'b1, 5'd1, 1'b0);
    bus.irq_lines = '0;
    step();
    bus.irq_lines = 16'h0011; bus.irq_ack = 1'b1;
    step(); bus.irq_ack = 1'b0;
    chk("t6_svc_busy", bus.irq_busy, 1'b1);
    chk("t6_svc_pend", bus.irq_pending, 16'h0011);
    #2 res = 1'b1;
    #1;
    chk_out("t6_async_rst", 1'b0, 5'd0, 1'b0);
    chk("t6_async_pend", bus.irq_pending, 0);
    step(); step();
    res = 1'b0; exp_q.push_back(5'd1);
    step();
    chk("t6_post_rst_edge", bus.irq_pending, 16'h0011);
    step();
    chk_out("t6_post_rst_req", 1'b1, 5'd1, 1'b0);
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller that produces the interrupt ID consumed by the processor's interrupt-ID latch.
- Collects N_IRQ external interrupt lines, rising-edge detects them into a pending register, and masks them with an enable vector.
- Selects the highest-priority pending line and presents it as a 5-bit ID with a request/acknowledge/return handshake.
- Sits between the peripheral interrupt sources and the core's trap logic. One interrupt is in flight at a time; there is no nesting.

Parameters:
- N_IRQ, 16, number of interrupt lines; legal range 1..31. Line i maps to ID i+1; ID 0 means "no interrupt".

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- irq_lines  in  N_IRQ  interrupt sources; already synchronous to clk.
- irq_en  in  N_IRQ  per-line enable mask; 1 = line may be requested.
- irq_ack  in  1  core has taken the interrupt; this is the enable that latches irq_id on the core side.
- irq_ret  in  1  core has finished the handler (mret); single-cycle pulse.
- irq_req  out  1  interrupt request to core; registered.
- irq_id  out  5  ID of requested or in-service interrupt; registered; 0 when idle.
- irq_busy  out  1  1 while in SERVICE state; registered.
- irq_pending  out  N_IRQ  raw pending register, for debug/CSR readback.

Behaviour:
- Reset (res=1, asynchronous):
  - state=IDLE; irq_req=0, irq_id=0, irq_busy=0.
  - pending=0; edge-history register=0.
  - Consequence: a line already high at the first clock after reset registers one edge.
- Edge detect:
  - pending[i] sets on any clock edge where irq_lines[i]=1 and history[i]=0.
  - history updates to irq_lines every cycle.
  - Pending sets regardless of irq_en. Level-high without a new edge never re-sets a bit.
- Candidate set = pending & irq_en. Priority: lowest index wins, giving the smallest nonzero ID.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - irq_req=0, irq_id=0.
  - If the candidate set is nonzero at a clock edge: go to REQ, irq_req<=1, irq_id<=winner+1.
- REQ:
  - irq_req=1 and irq_id are held stable.
  - A later higher-priority arrival does not change irq_id (no preemption of a posted request).
  - Clearing irq_en for the requested line does not withdraw the request.
  - On irq_ack=1: pending[irq_id-1]<=0, irq_req<=0, irq_busy<=1, go to SERVICE. irq_id is held.
- SERVICE:
  - irq_id is held and irq_busy=1.
  - On irq_ret=1: go to IDLE, irq_id<=0, irq_busy<=0.
  - New edges continue to set pending throughout.
- Latency:
  - Rising line sampled at edge k: pending=1 after k, irq_req=1 and irq_id valid after k+1 (2 cycles).
  - Back-to-back: irq_ret at edge m returns to IDLE after m. The next pending candidate raises irq_req after m+1, so there is at least one idle cycle between interrupts.
- Simultaneous events:
  - Set and clear of the same pending bit in one cycle (new edge coinciding with ack): set wins, and the bit stays 1.
  - irq_ack outside REQ is ignored. irq_ret outside SERVICE is ignored.
  - irq_ack and irq_ret both high in REQ: only ack is acted on, going to SERVICE.
- Reset mid-operation: an immediate return to IDLE with all outputs 0 and pending cleared; in-flight interrupts are lost.
- Width: the winner index is encoded in 5 bits as index+1. N_IRQ>31 is illegal and flagged by an elaboration check.

Test Plan:
- Reset, then rise irq_lines[3] with irq_en=all 1 -> pending[3]=1 after 1 cycle; irq_req=1 and irq_id=4 after 2 cycles; held until ack.
- In REQ with irq_id=4, rise line 0 -> irq_id stays 4. Ack -> SERVICE, pending[3]=0. irq_ret -> IDLE for 1 cycle, then irq_req=1 with irq_id=1.
- irq_en[5]=0, rise line 5 -> pending[5]=1, irq_req stays 0. Set irq_en[5]=1 -> irq_req=1 and irq_id=6 one cycle later.
- Rise line 2 again in the same cycle irq_ack clears it (irq_id=3) -> pending[2] stays 1. After irq_ret, line 2 is re-requested with irq_id=3.
- Hold irq_lines[7] high across ack/ret without a new edge -> only one request, irq_id=8. Stray irq_ack in IDLE and irq_ret in REQ cause no state change.
- Assert res during SERVICE with pending=0x0011 -> irq_req=0, irq_id=0, irq_busy=0, pending=0 immediately (asynchronous, before the next clk edge).
